rvh_tlb_miss_arb: RTL and testbench

- Parametrised arbiter between N TLB miss sources (ITLB, DTLB, and further ports such as a second DTLB or a prefetch TLB) and the single page-table walker (PTW) request port.
- Fixed-priority or round-robin grant.
- Registered valid/ready request channel to the PTW.
- One walk outstanding at a time. The PTW response is steered back to the requester that won the grant.
- A flush discards an in-flight walk safely.

---
 rtl/rvh_mmu_pkg.sv | 21 ++
 rtl/rvh_arb_pick.sv | 80 ++++++++
 rtl/rvh_tlb_miss_arb.sv | 176 +++++++++++++++++
 tb/tb_rvh_tlb_miss_arb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_mmu_pkg.sv
// -----------------------------------------------------------------------------
// rvh_mmu_pkg
// Shared MMU definitions: default VPN width (Sv39), arbitration mode encodings
// and the state type used by the TLB miss arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package rvh_mmu_pkg;

  localparam int VPN_W_DEF = 27;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rvh_arb_pick.sv
// -----------------------------------------------------------------------------
// rvh_arb_pick
// Purely combinational requester pick, shared by the MMU arbiters.
// Ports:
//   vld      in  N     request valid vector
//   mode     in  1     ARB_FIXED or ARB_RR
//   prio_idx in  ID_W  preferred requester in fixed mode
//   ptr      in  ID_W  round-robin search start
//   gnt      out N     one-hot grant (all zero when nothing valid)
//   gnt_idx  out ID_W  binary index of the grant
//   any      out 1     at least one requester valid
// -----------------------------------------------------------------------------
module rvh_arb_pick
  import rvh_mmu_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    vld,
  input  logic            mode,
  input  logic [ID_W-1:0] prio_idx,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  logic found_s;
  int   cand_s;

  // Select the winning index according to the mode.
  always_comb begin
    found_s = 1'b0;
    cand_s  = 0;
    gnt_idx = '0;
    any     = |vld;
    if (mode == ARB_RR) begin
      // Walk N slots starting at ptr; the wrap is an explicit subtract so a
      // non power-of-two N never lands on a non-existent requester.
      for (int k = 0; k < N; k++) begin
        cand_s = int'(ptr) + k;
        cand_s = (cand_s >= N) ? (cand_s - N) : cand_s;
        if (!found_s && vld[cand_s]) begin
          found_s = 1'b1;
          gnt_idx = ID_W'(cand_s);
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      // Preferred requester first, then lowest valid index.
      for (int k = 0; k < N; k++) begin
        if (vld[k] && (k == int'(prio_idx))) begin
          found_s = 1'b1;
          gnt_idx = ID_W'(k);
        end else begin
          found_s = found_s;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (!found_s && vld[k]) begin
          found_s = 1'b1;
          gnt_idx = ID_W'(k);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Expand the winning index to a one-hot grant.
  always_comb begin
    if (found_s) begin
      gnt = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/rvh_tlb_miss_arb.sv
// -----------------------------------------------------------------------------
// rvh_tlb_miss_arb
// Arbitrates N TLB miss sources onto the single PTW request port, keeps one
// walk outstanding, and steers the walk response back to the winner. A flush
// abandons the current transaction; a walk already handed to the PTW is
// drained so its late response never reaches a requester.
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   flush_i           pipeline / sfence flush
//   miss_req_vld_i    per-requester miss valid
//   miss_req_vpn_i    per-requester VPN, requester k at [k*VPN_W +: VPN_W]
//   miss_req_rdy_o    one-hot accept (combinational, IDLE only)
//   ptw_req_vld_o     request valid to PTW (registered)
//   ptw_req_vpn_o     request VPN (registered)
//   ptw_req_id_o      index of granted requester (registered)
//   ptw_req_rdy_i     PTW accepts the request
//   ptw_resp_vld_i    walk complete pulse
//   miss_resp_vld_o   one-hot response pulse to the owner (combinational)
//   busy_o            high whenever not IDLE (registered)
// -----------------------------------------------------------------------------
module rvh_tlb_miss_arb
  import rvh_mmu_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int VPN_W     = VPN_W_DEF,
  parameter int RR_MODE   = 0,
  parameter int PRIOR_IDX = 1,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [N_REQ-1:0]       miss_req_vld_i,
  input  logic [N_REQ*VPN_W-1:0] miss_req_vpn_i,
  output logic [N_REQ-1:0]       miss_req_rdy_o,
  output logic                   ptw_req_vld_o,
  output logic [VPN_W-1:0]       ptw_req_vpn_o,
  output logic [ID_W-1:0]        ptw_req_id_o,
  input  logic                   ptw_req_rdy_i,
  input  logic                   ptw_resp_vld_i,
  output logic [N_REQ-1:0]       miss_resp_vld_o,
  output logic                   busy_o
);

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [VPN_W-1:0] vpn_r;
  logic [ID_W-1:0]  id_r;
  logic [ID_W-1:0]  ptr_r;
  logic             ptw_vld_r;
  logic             busy_r;

  logic [N_REQ-1:0] gnt_s;
  logic [ID_W-1:0]  gnt_idx_s;
  logic             any_s;
  logic             accept_s;
  logic             handshake_s;

  rvh_arb_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .vld      (miss_req_vld_i),
    .mode     ((RR_MODE != 0) ? ARB_RR : ARB_FIXED),
    .prio_idx (ID_W'(PRIOR_IDX)),
    .ptr      (ptr_r),
    .gnt      (gnt_s),
    .gnt_idx  (gnt_idx_s),
    .any      (any_s)
  );

  // rst gates the accept so no ready escapes while reset is held.
  assign accept_s    = (state_r == IDLE) && any_s && !flush_i && !rst;
  assign handshake_s = (state_r == REQ) && ptw_req_rdy_i;

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        // A flush coinciding with the handshake cannot recall the walk, so
        // its response must be swallowed in DRAIN.
        if (ptw_req_rdy_i) begin
          state_nxt_s = flush_i ? DRAIN : WAIT;
        end else if (flush_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (ptw_resp_vld_i) begin
          state_nxt_s = IDLE;
        end else if (flush_i) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DRAIN: begin
        if (ptw_resp_vld_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Combinational accept and response steering.
  always_comb begin
    miss_req_rdy_o  = '0;
    miss_resp_vld_o = '0;
    if (accept_s) begin
      miss_req_rdy_o = gnt_s;
    end else begin
      miss_req_rdy_o = '0;
    end
    if ((state_r == WAIT) && ptw_resp_vld_i && !flush_i) begin
      miss_resp_vld_o = {{(N_REQ-1){1'b0}}, 1'b1} << id_r;
    end else begin
      miss_resp_vld_o = '0;
    end
  end

  // State register plus registered request-valid and busy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ptw_vld_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ptw_vld_r <= (state_nxt_s == REQ);
      busy_r    <= (state_nxt_s != IDLE);
    end
  end

  // Capture the winner's VPN and index on accept; held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpn_r <= '0;
      id_r  <= '0;
    end else if (accept_s) begin
      vpn_r <= miss_req_vpn_i[int'(gnt_idx_s)*VPN_W +: VPN_W];
      id_r  <= gnt_idx_s;
    end
  end

  // Round-robin pointer. It only advances once the walk is committed to the
  // PTW; the pointer is never consulted between accept and handshake, so a
  // request flushed in REQ leaves the rotation exactly where it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (handshake_s) begin
      ptr_r <= (id_r == ID_W'(N_REQ - 1)) ? '0 : (id_r + ID_W'(1));
    end
  end

  assign ptw_req_vld_o = ptw_vld_r;
  assign ptw_req_vpn_o = vpn_r;
  assign ptw_req_id_o  = id_r;
  assign busy_o        = busy_r;

endmodule

// File: tb/tb_rvh_tlb_miss_arb.sv
// -----------------------------------------------------------------------------
// tb_rvh_tlb_miss_arb
// Two instances: A = fixed priority, N_REQ=2, PRIOR_IDX=1; B = round-robin,
// N_REQ=3. 'sel' routes the shared stimulus to one of them (the other sees
// no valids and stays idle). Expected winners come from a transaction-level
// model of the grant rules.
// -----------------------------------------------------------------------------
module tb_rvh_tlb_miss_arb;

  localparam int VW = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, ptw_rdy, resp, sel;
  logic [2:0]    vld;
  logic [3*VW-1:0] vpn;
  logic [1:0]    vld_a;
  logic [2:0]    vld_b;

  logic [1:0]    rdy_a, respo_a;
  logic          pvld_a, busy_a;
  logic [VW-1:0] pvpn_a;
  logic [0:0]    pid_a;
  logic [2:0]    rdy_b, respo_b;
  logic          pvld_b, busy_b;
  logic [VW-1:0] pvpn_b;
  logic [1:0]    pid_b;

  logic [2:0]    o_rdy, o_resp;
  logic          o_pvld, o_busy;
  logic [VW-1:0] o_pvpn;
  logic [1:0]    o_pid;

  assign vld_a  = sel ? 2'b00 : vld[1:0];
  assign vld_b  = sel ? vld : 3'b000;
  assign o_rdy  = sel ? rdy_b : {1'b0, rdy_a};
  assign o_resp = sel ? respo_b : {1'b0, respo_a};
  assign o_pvld = sel ? pvld_b : pvld_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_pvpn = sel ? pvpn_b : pvpn_a;
  assign o_pid  = sel ? pid_b : {1'b0, pid_a};

  rvh_tlb_miss_arb #(.N_REQ(2), .VPN_W(VW), .RR_MODE(0), .PRIOR_IDX(1)) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush),
    .miss_req_vld_i(vld_a), .miss_req_vpn_i(vpn[2*VW-1:0]), .miss_req_rdy_o(rdy_a),
    .ptw_req_vld_o(pvld_a), .ptw_req_vpn_o(pvpn_a), .ptw_req_id_o(pid_a),
    .ptw_req_rdy_i(ptw_rdy), .ptw_resp_vld_i(resp),
    .miss_resp_vld_o(respo_a), .busy_o(busy_a)
  );

  rvh_tlb_miss_arb #(.N_REQ(3), .VPN_W(VW), .RR_MODE(1), .PRIOR_IDX(1)) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush),
    .miss_req_vld_i(vld_b), .miss_req_vpn_i(vpn), .miss_req_rdy_o(rdy_b),
    .ptw_req_vld_o(pvld_b), .ptw_req_vpn_o(pvpn_b), .ptw_req_id_o(pid_b),
    .ptw_req_rdy_i(ptw_rdy), .ptw_resp_vld_i(resp),
    .miss_resp_vld_o(respo_b), .busy_o(busy_b)
  );

  int            checks = 0;
  int            errors = 0;
  int            ptr_m  = 0;
  logic [VW-1:0] vm [3];

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nreq();
    return sel ? 3 : 2;
  endfunction

  // Grant rules: fixed -> requester 1 if valid else lowest; RR -> first valid
  // scanning upward from the pointer, modulo N.
  function automatic int model_pick(input logic [2:0] v);
    if (!sel) begin
      if (v[1]) return 1;
      for (int i = 0; i < 2; i++) if (v[i]) return i;
    end else begin
      for (int k = 0; k < 3; k++) if (v[(ptr_m + k) % 3]) return (ptr_m + k) % 3;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_vpns();
    for (int i = 0; i < 3; i++) vm[i] = VW'($urandom);
    vpn = {vm[2], vm[1], vm[0]};
  endtask

  // IDLE cycle: present v, check the accept, leave the state in REQ.
  task automatic accept(input logic [2:0] v, output int w);
    logic [2:0] oh;
    vld = v; flush = 1'b0; ptw_rdy = 1'b0; resp = 1'b0;
    #1;
    w  = model_pick(v);
    oh = 3'b001 << w;
    chk("accept_rdy", o_rdy, oh);
    chk("idle_busy", o_busy, 1'b0);
    chk("idle_pvld", o_pvld, 1'b0);
    tick();
    vld = v & ~oh;
  endtask

  // REQ cycle with PTW ready: check the request, then advance to WAIT.
  task automatic handshake(input int w);
    ptw_rdy = 1'b1;
    #1;
    chk("hs_vld", o_pvld, 1'b1);
    chk("hs_vpn", o_pvpn, vm[w]);
    chk("hs_id", o_pid, w[1:0]);
    tick();
    ptw_rdy = 1'b0;
    ptr_m = (w + 1) % nreq();
  endtask

  task automatic walk(input logic [2:0] v, input int hold, input int lat);
    int w;
    accept(v, w);
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("req_vld", o_pvld, 1'b1);
      chk("req_vpn", o_pvpn, vm[w]);
      chk("req_id", o_pid, w[1:0]);
      chk("req_no_accept", o_rdy, 3'b000);
      chk("req_busy", o_busy, 1'b1);
      tick();
    end
    handshake(w);
    for (int i = 0; i < lat; i++) begin
      #1;
      chk("wait_pvld", o_pvld, 1'b0);
      chk("wait_resp", o_resp, 3'b000);
      chk("wait_busy", o_busy, 1'b1);
      tick();
    end
    resp = 1'b1;
    #1;
    chk("resp_onehot", o_resp, 3'b001 << w);
    tick();
    resp = 1'b0;
  endtask

  initial begin
    int w;
    int w_prev;
    rst = 1'b1; flush = 1'b0; ptw_rdy = 1'b0; resp = 1'b0; sel = 1'b0;
    vld = 3'b011; vpn = '0;
    tick(); tick();
    // Reset state, with valids present.
    chk("rst_rdy", o_rdy, 3'b000);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_pvld", o_pvld, 1'b0);
    chk("rst_pvpn", o_pvpn, '0);
    chk("rst_pid", o_pid, 2'b00);
    vld = 3'b000;
    rst = 1'b0;
    tick();

    // Fixed priority directed: requester 1 wins, then 0 right after response.
    vm[0] = 27'h1000; vm[1] = 27'h2000; vm[2] = 27'h0;
    vpn = {vm[2], vm[1], vm[0]};
    walk(3'b011, 0, 2);
    walk(3'b001, 0, 1);
    // Back-pressure for 5 cycles with the other requester waiting.
    walk(3'b011, 5, 1);

    // Fixed priority random.
    for (int n = 0; n < 20; n++) begin
      new_vpns();
      walk(3'($urandom_range(3, 1)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
    end

    // Flush in IDLE blocks accept; response in IDLE is ignored.
    vld = 3'b011; flush = 1'b1;
    #1;
    chk("flush_idle_rdy", o_rdy, 3'b000);
    tick();
    vld = 3'b000; flush = 1'b0;
    #1;
    chk("flush_idle_busy", o_busy, 1'b0);
    resp = 1'b1;
    #1;
    chk("idle_resp_ignored", o_resp, 3'b000);
    tick();
    resp = 1'b0;
    #1;
    chk("idle_resp_busy", o_busy, 1'b0);

    // Round-robin, all valid: order 0,1,2,0.
    sel = 1'b1; ptr_m = 0;
    new_vpns();
    for (int n = 0; n < 4; n++) walk(3'b111, 0, 2);
    for (int n = 0; n < 25; n++) begin
      new_vpns();
      walk(3'($urandom_range(7, 1)), int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
    end

    // Flush in WAIT, response 3 cycles later: swallowed in DRAIN.
    accept(3'b111, w);
    handshake(w);
    flush = 1'b1;
    #1;
    chk("wflush_resp", o_resp, 3'b000);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drain_busy", o_busy, 1'b1);
      chk("drain_resp", o_resp, 3'b000);
      tick();
    end
    resp = 1'b1;
    #1;
    chk("drain_swallow", o_resp, 3'b000);
    chk("drain_busy_last", o_busy, 1'b1);
    tick();
    resp = 1'b0;
    #1;
    chk("drain_exit_busy", o_busy, 1'b0);

    // Flush with same-cycle response in WAIT.
    accept(3'b111, w);
    handshake(w);
    flush = 1'b1; resp = 1'b1;
    #1;
    chk("wflush_resp_same", o_resp, 3'b000);
    tick();
    flush = 1'b0; resp = 1'b0;
    #1;
    chk("wflush_same_busy", o_busy, 1'b0);

    // Flush in REQ without ready: no walk, pointer stays.
    accept(3'b111, w_prev);
    flush = 1'b1;
    #1;
    chk("rflush_busy", o_busy, 1'b1);
    tick();
    flush = 1'b0; vld = 3'b111;
    #1;
    chk("rflush_idle", o_busy, 1'b0);
    chk("rflush_pvld", o_pvld, 1'b0);
    chk("rr_ptr_unchanged", o_rdy, 3'b001 << w_prev);
    vld = 3'b000;
    #1;
    tick();

    // Flush coinciding with handshake -> DRAIN; flush in DRAIN ignored.
    accept(3'b111, w);
    flush = 1'b1; ptw_rdy = 1'b1;
    tick();
    ptw_rdy = 1'b0;
    ptr_m = (w + 1) % 3;
    #1;
    chk("hsflush_busy", o_busy, 1'b1);
    chk("hsflush_pvld", o_pvld, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    chk("drain_flush_ignored", o_busy, 1'b1);
    resp = 1'b1;
    #1;
    chk("hsflush_swallow", o_resp, 3'b000);
    tick();
    resp = 1'b0;
    #1;
    chk("hsflush_exit", o_busy, 1'b0);

    // Response while in REQ is ignored and the request stays up.
    accept(3'b111, w);
    resp = 1'b1;
    #1;
    chk("req_resp_ignored", o_resp, 3'b000);
    tick();
    resp = 1'b0;
    #1;
    chk("req_still_vld", o_pvld, 1'b1);
    handshake(w);
    resp = 1'b1;
    #1;
    chk("req_resp_late", o_resp, 3'b001 << w);
    tick();
    resp = 1'b0;

    // Asynchronous reset in WAIT with a non-zero pointer.
    new_vpns();
    accept(3'b001, w);
    handshake(w);
    vld = 3'b111;
    #2;
    rst = 1'b1; resp = 1'b1;
    #1;
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_pvld", o_pvld, 1'b0);
    chk("arst_pvpn", o_pvpn, '0);
    chk("arst_pid", o_pid, 2'b00);
    chk("arst_resp", o_resp, 3'b000);
    chk("arst_rdy", o_rdy, 3'b000);
    tick();
    rst = 1'b0; vld = 3'b000;
    ptr_m = 0;
    #1;
    chk("stale_resp", o_resp, 3'b000);
    tick();
    resp = 1'b0;
    #1;
    chk("stale_busy", o_busy, 1'b0);
    walk(3'b111, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
